// File: rtl/pipelined_normalizer.sv
// rtl/pipelined_normalizer.sv - two-stage leading-one normalizer with exponent adjust and flags
module pipelined_normalizer #(
    parameter int MANTISSA_N = 25,
    parameter int EXP_N      = 8,
    parameter int TARGET_BIT = 23
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [MANTISSA_N-1:0] mantissa,
    input  logic [EXP_N-1:0]      exp,
    input  logic                  inSticky,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [MANTISSA_N-1:0] normedMantissa,
    output logic [EXP_N-1:0]      normedExp,
    output logic                  sticky,
    output logic                  zero,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int SHIFT_N = $clog2(MANTISSA_N);
    localparam int EW      = EXP_N + 2;
    localparam logic signed [EW-1:0] EXP_SAT  = EW'((1 << EXP_N) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;

    // Reset asserts immediately, releases two clocks after reset_n rises
    logic [1:0] rst_sync;
    logic       rst_i;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i = rst_sync[1];

    logic s1_valid;
    logic s1_adv, s2_adv;

    assign s2_adv  = ~outValid | outReady;
    assign s1_adv  = ~s1_valid | s2_adv;
    assign inReady = s1_adv & rst_i;

    logic               lod_found;
    logic [SHIFT_N-1:0] lod_idx;

    always_comb begin
        lod_found = 1'b0;
        lod_idx   = '0;
        for (int i = 0; i < MANTISSA_N; i++) begin
            if (mantissa[i]) begin
                lod_found = 1'b1;
                lod_idx   = SHIFT_N'(i);
            end
        end
    end

    logic [MANTISSA_N-1:0] s1_mant;
    logic [EXP_N-1:0]      s1_exp;
    logic                  s1_sticky;
    logic [SHIFT_N-1:0]    s1_idx;
    logic                  s1_found;

    always_ff @(posedge clock or negedge rst_i) begin
        if (!rst_i) begin
            s1_valid  <= 1'b0;
            s1_mant   <= '0;
            s1_exp    <= '0;
            s1_sticky <= 1'b0;
            s1_idx    <= '0;
            s1_found  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= inValid;
            if (inValid) begin
                s1_mant   <= mantissa;
                s1_exp    <= exp;
                s1_sticky <= inSticky;
                s1_idx    <= lod_idx;
                s1_found  <= lod_found;
            end
        end
    end

    logic [SHIFT_N-1:0]    rsh, lsh;
    logic [MANTISSA_N-1:0] lost_mask, shifted;
    logic signed [EW-1:0]  exp_c;
    logic [MANTISSA_N-1:0] n_mant;
    logic [EXP_N-1:0]      n_exp;
    logic                  n_sticky, n_zero, n_ovf, n_unf;

    always_comb begin
        rsh = '0;
        lsh = '0;
        if (s1_idx > SHIFT_N'(TARGET_BIT)) rsh = s1_idx - SHIFT_N'(TARGET_BIT);
        else                               lsh = SHIFT_N'(TARGET_BIT) - s1_idx;
        lost_mask = ~({MANTISSA_N{1'b1}} << rsh);
        shifted   = (s1_mant >> rsh) << lsh;
        // Widened signed exponent so both saturation limits are visible
        exp_c = $signed({2'b00, s1_exp}) + $signed(EW'(s1_idx)) - $signed(EW'(TARGET_BIT));

        n_mant   = '0;
        n_exp    = '0;
        n_sticky = s1_sticky | (|(s1_mant & lost_mask));
        n_zero   = 1'b0;
        n_ovf    = 1'b0;
        n_unf    = 1'b0;
        if (!s1_found) begin
            n_zero   = 1'b1;
            n_sticky = s1_sticky;
        end else if (exp_c >= EXP_SAT) begin
            n_ovf = 1'b1;
            n_exp = '1;
        end else if (exp_c <= EXP_ZERO) begin
            n_unf    = 1'b1;
            n_sticky = 1'b1;
        end else begin
            n_exp  = exp_c[EXP_N-1:0];
            n_mant = shifted;
        end
    end

    always_ff @(posedge clock or negedge rst_i) begin
        if (!rst_i) begin
            outValid       <= 1'b0;
            normedMantissa <= '0;
            normedExp      <= '0;
            sticky         <= 1'b0;
            zero           <= 1'b0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else if (s2_adv) begin
            outValid <= s1_valid;
            if (s1_valid) begin
                normedMantissa <= n_mant;
                normedExp      <= n_exp;
                sticky         <= n_sticky;
                zero           <= n_zero;
                overflow       <= n_ovf;
                underflow      <= n_unf;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_normalizer.sv
// tb/tb_pipelined_normalizer.sv - randomized scoreboard bench for pipelined_normalizer
module tb_pipelined_normalizer;
    localparam int MN = 25;
    localparam int EN = 8;
    localparam int TB = 23;

    logic          clock = 1'b0;
    logic          reset_n, inValid, inReady, inSticky, outValid, outReady;
    logic [MN-1:0] mantissa, normedMantissa;
    logic [EN-1:0] exp, normedExp;
    logic          sticky, zero, overflow, underflow;

    always #5 clock = ~clock;

    pipelined_normalizer #(.MANTISSA_N(MN), .EXP_N(EN), .TARGET_BIT(TB)) dut (
        .clock(clock), .reset_n(reset_n), .inValid(inValid), .inReady(inReady),
        .mantissa(mantissa), .exp(exp), .inSticky(inSticky),
        .outValid(outValid), .outReady(outReady), .normedMantissa(normedMantissa),
        .normedExp(normedExp), .sticky(sticky), .zero(zero),
        .overflow(overflow), .underflow(underflow)
    );

    typedef struct packed {
        logic [MN-1:0] m;
        logic [EN-1:0] e;
        logic          s, z, o, u;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   out_count = 0;
    bit   took = 0;
    bit   stall_prev = 0;
    res_t prev_out;
    res_t q[$];

    function automatic res_t model(input logic [MN-1:0] m, input logic [EN-1:0] e, input logic st);
        res_t    r;
        longint  mm, p;
        int      idx, ec;
        r   = '0;
        r.s = st;
        if (m == 0) begin
            r.z = 1'b1;
            return r;
        end
        mm  = longint'(m);
        idx = 0;
        while (mm > 1) begin
            mm  = mm / 2;
            idx = idx + 1;
        end
        ec = int'(e) + idx - TB;
        if (idx > TB) begin
            p   = longint'(1) << (idx - TB);
            r.m = MN'(longint'(m) / p);
            if (longint'(m) % p != 0) r.s = 1'b1;
        end else begin
            r.m = MN'(longint'(m) * (longint'(1) << (TB - idx)));
        end
        if (ec >= 255) begin
            r.o = 1'b1; r.e = '1; r.m = '0;
        end else if (ec <= 0) begin
            r.u = 1'b1; r.e = '0; r.m = '0; r.s = 1'b1;
        end else begin
            r.e = EN'(ec);
        end
        return r;
    endfunction

    function automatic res_t dut_out();
        return {normedMantissa, normedExp, sticky, zero, overflow, underflow};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        res_t a, x;
        took = inValid && inReady;
        if (reset_n) begin
            a = dut_out();
            if (inValid && inReady) q.push_back(model(mantissa, exp, inSticky));
            if (stall_prev) begin
                check("held_valid", 64'(outValid), 64'd1);
                check("held_data", 64'(a), 64'(prev_out));
            end
            if (outValid && outReady) begin
                out_count++;
                if (q.size() == 0) begin
                    check("unexpected_beat", 64'(outValid), 64'd0);
                end else begin
                    x = q.pop_front();
                    check("beat", 64'(a), 64'(x));
                end
            end
            stall_prev = outValid && !outReady;
            prev_out   = a;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input logic [MN-1:0] m, input logic [EN-1:0] e, input logic s);
        int n;
        mantissa = m; exp = e; inSticky = s; inValid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!inReady && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (!inReady) check("send_timeout", 64'(inReady), 64'd1);
        @(posedge clock);
        #1 inValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            n++;
            @(negedge clock);
        end
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        res_t r;
        int   base;
        reset_n = 1'b0; inValid = 1'b0; outReady = 1'b0;
        mantissa = '0; exp = '0; inSticky = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_outvalid", 64'(outValid), 64'd0);
        check("reset_outputs", 64'(dut_out()), 64'd0);
        do_reset();
        @(negedge clock);
        check("reset_inready", 64'(inReady), 64'd1);

        r = model(25'h0000100, 8'd100, 1'b0);
        check("model_left", 64'(r), 64'({25'h0800000, 8'd85, 4'b0000}));
        r = model(25'h1800001, 8'd100, 1'b0);
        check("model_right", 64'(r), 64'({25'h0C00000, 8'd101, 4'b1000}));
        r = model(25'h1000000, 8'd254, 1'b0);
        check("model_ovf", 64'(r), 64'({25'h0, 8'd255, 4'b0010}));
        r = model(25'h0000001, 8'd10, 1'b0);
        check("model_unf", 64'(r), 64'({25'h0, 8'd0, 4'b1001}));
        r = model(25'h0, 8'd77, 1'b1);
        check("model_zero", 64'(r), 64'({25'h0, 8'd0, 4'b1100}));

        @(posedge clock); #1 outReady = 1'b1;
        send(25'h0000100, 8'd100, 1'b0);
        @(negedge clock);
        check("latency_not_early", 64'(outValid), 64'd0);
        @(negedge clock);
        check("latency_valid", 64'(outValid), 64'd1);
        check("latency_mant", 64'(normedMantissa), 64'h0800000);
        check("latency_exp", 64'(normedExp), 64'd85);
        send(25'h1800001, 8'd100, 1'b0);
        send(25'h1000000, 8'd254, 1'b0);
        send(25'h0000001, 8'd10, 1'b0);
        send(25'h0000000, 8'd77, 1'b1);
        drain();

        // Backpressure: A at output, B in stage 1, C blocked
        @(posedge clock); #1 outReady = 1'b0;
        base = out_count;
        send(25'h0000abc, 8'd50, 1'b0);
        send(25'h1fff000, 8'd60, 1'b1);
        mantissa = 25'h0400000; exp = 8'd70; inSticky = 1'b0; inValid = 1'b1;
        repeat (4) begin
            @(negedge clock);
            check("stall_inready", 64'(inReady), 64'd0);
            check("stall_outvalid", 64'(outValid), 64'd1);
        end
        @(posedge clock); #1 outReady = 1'b1;
        @(negedge clock);
        while (!inReady) @(negedge clock);
        @(posedge clock); #1 inValid = 1'b0;
        drain();
        check("abc_count", 64'(out_count - base), 64'd3);

        // Reset with two beats in flight
        send(25'h0001234, 8'd90, 1'b0);
        send(25'h0005678, 8'd91, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check("midreset_outvalid", 64'(outValid), 64'd0);
        check("midreset_outputs", 64'(dut_out()), 64'd0);
        q.delete();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("postreset_inready", 64'(inReady), 64'd1);
        base = out_count;
        repeat (6) @(negedge clock);
        check("no_stale_beat", 64'(out_count - base), 64'd0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            outReady = ($urandom % 4) != 0;
            if (!inValid || took) begin
                if ($urandom % 3 != 0) begin
                    inValid  = 1'b1;
                    mantissa = MN'($urandom) & ((MN'(1) << $urandom_range(0, MN)) - MN'(1));
                    case ($urandom % 6)
                        0: exp = 8'd0;
                        1: exp = 8'd1;
                        2: exp = 8'd254;
                        3: exp = 8'd255;
                        default: exp = EN'($urandom);
                    endcase
                    inSticky = ($urandom % 4) == 0;
                end else begin
                    inValid = 1'b0;
                end
            end
        end
        @(posedge clock); #1 outReady = 1'b1;
        @(negedge clock);
        while (inValid && !took) @(negedge clock);
        #1 inValid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/pipelined_normalizer.md
Name: pipelined_normalizer

Overview:
Two-stage pipelined normalizer for the floating-point adder datapath. It takes a raw sum mantissa and a biased exponent and locates the leading one. It then shifts left or right so the leading one lands at TARGET_BIT and adjusts the exponent to match. It also produces a sticky bit and zero/overflow/underflow flags. The block sits between the mantissa adder and the rounding stage, with valid/ready handshakes on both sides.

Parameters:
MANTISSA_N, 25, mantissa width including carry/guard bits
EXP_N, 8, exponent width (unsigned, biased)
TARGET_BIT, 23, bit position of the normalized leading one (must be < MANTISSA_N)
SHIFT_N, $clog2(MANTISSA_N), shift-amount width (localparam)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
inValid  input  1  input beat valid
inReady  output  1  block can accept a beat this cycle
mantissa  input  MANTISSA_N  unnormalized mantissa
exp  input  EXP_N  biased exponent of mantissa
inSticky  input  1  sticky bit from the upstream alignment shift
outValid  output  1  output beat valid
outReady  input  1  downstream accepts a beat
normedMantissa  output  MANTISSA_N  normalized mantissa
normedExp  output  EXP_N  adjusted exponent
sticky  output  1  inSticky OR any 1 bits shifted out on a right shift
zero  output  1  input mantissa was all zeros
overflow  output  1  exponent saturated
underflow  output  1  result flushed to zero

Behaviour:
- Reset (async assert, sync deassert inside the block): both stage valids = 0; all output registers = 0; inReady = 1 after reset.
- Stage 1 register: captures mantissa, exp, inSticky, the leading-one index (0..MANTISSA_N-1) and a found flag.
- Stage 2 register: drives all outputs; holds the shifted mantissa, the adjusted exponent and the flags.
- Latency is 2 cycles from accepted input to outValid when there is no backpressure. Throughput is 1 beat per cycle.
- Handshake:
  - Stage 2 advances when ~outValid | outReady.
  - Stage 1 advances when ~s1Valid | stage 2 advances.
  - inReady = stage 1 advance (combinational ready chain).
  - A beat is transferred when valid & ready.
  - Outputs are held stable while outValid & ~outReady.
  - Beats are never dropped or reordered.
- Normalization, for a leading-one index idx:
  - idx > TARGET_BIT: right shift by idx-TARGET_BIT. sticky = inSticky | OR(bits shifted out). Exponent candidate = exp + (idx-TARGET_BIT).
  - idx < TARGET_BIT: left shift by TARGET_BIT-idx with zero fill. sticky = inSticky. Exponent candidate = exp - (TARGET_BIT-idx).
  - idx == TARGET_BIT: no shift; exponent unchanged; sticky = inSticky.
- Exponent arithmetic is computed at EXP_N+2 bits, signed, to avoid wrap.
  - Candidate >= 2^EXP_N-1: overflow=1, normedExp = all ones, normedMantissa = 0.
  - Candidate <= 0: underflow=1, normedExp = 0, normedMantissa = 0, sticky = 1. Denormals are not produced.
- Zero input (no one found): zero=1, normedExp = 0, normedMantissa = 0, sticky = inSticky, overflow = underflow = 0.
- Overflow and underflow are mutually exclusive with each other and with zero.
- Reset asserted mid-operation: all in-flight beats are discarded and outValid drops immediately.

Test Plan:
- mantissa=0x0000100, exp=100, outReady=1 -> 2 cycles later: normedMantissa=0x0800000, normedExp=85, sticky=0, flags 0.
- mantissa=0x1800001, exp=100, inSticky=0 -> normedMantissa=0x0C00000, normedExp=101, sticky=1.
- mantissa=0x1000000, exp=254 -> overflow=1, normedExp=255, normedMantissa=0. Separately, mantissa=0x0000001, exp=10 -> underflow=1, normedExp=0, normedMantissa=0, sticky=1.
- mantissa=0, exp=77, inSticky=1 -> zero=1, normedExp=0, normedMantissa=0, sticky=1.
- Back-to-back beats A, B, C with outReady=0 for 4 cycles:
  - A is held at the output, B is held in stage 1, inReady=0 while C is presented.
  - When outReady rises, A, B, C emerge in order, one per cycle, with no duplicates.
- Assert reset_n=0 with 2 beats in flight -> outValid=0 and all outputs 0 in the same cycle; after release inReady=1 and no stale beat appears.
